// File: rtl/stack_pkg.sv
// Shared encodings for the 16-bit stack processor: opcodes, micro-op codes, data selects.
// Used by the decoder, the control wrapper and the interface.
package stack_pkg;

    localparam int WORD = 16;

    localparam logic [4:0] OP_NOP      = 5'h00;
    localparam logic [4:0] OP_ALU_BASE = 5'h01;
    localparam logic [4:0] OP_ALU_LAST = 5'h08;
    localparam logic [4:0] OP_DUP      = 5'h09;
    localparam logic [4:0] OP_DROP     = 5'h0A;
    localparam logic [4:0] OP_SWAP     = 5'h0B;
    localparam logic [4:0] OP_OVER     = 5'h0C;
    localparam logic [4:0] OP_TOR      = 5'h0D;
    localparam logic [4:0] OP_FROMR    = 5'h0E;
    localparam logic [4:0] OP_FETCH    = 5'h0F;
    localparam logic [4:0] OP_FLAGS    = 5'h10;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SHL, ALU_SHR
    } alu_op_e;

    typedef enum logic [3:0] {
        DS_NOP     = 4'd0,
        DS_PUSH    = 4'd1,
        DS_POP     = 4'd2,
        DS_DUP     = 4'd3,
        DS_SWAP    = 4'd4,
        DS_OVER    = 4'd5,
        DS_POP2    = 4'd6,
        DS_REPLACE = 4'd7
    } ds_op_e;

    typedef enum logic [3:0] {
        RS_NOP  = 4'd0,
        RS_PUSH = 4'd1,
        RS_POP  = 4'd2
    } rs_op_e;

    typedef enum logic [1:0] {
        SEL_LIT, SEL_RS0, SEL_MEM, SEL_FLAGS
    } sel_e;

    typedef struct packed {
        alu_op_e          aluop;
        ds_op_e           dsop;
        rs_op_e           rsop;
        logic             sr1_ow;
        logic [WORD-1:0]  lit;
        sel_e             sel;
    } uop_t;

endpackage

// File: rtl/stack_control_if.sv
// Bundle between the decode/sequencing unit and the fetch/stack/ALU datapath.
// master = stack_control side, slave = datapath side.
interface stack_control_if;
    import stack_pkg::*;

    logic [2:0]      STATUS;
    logic [WORD-1:0] ALUOUT;
    logic [WORD-1:0] sr0;
    logic [WORD-1:0] sr1;
    logic [WORD-1:0] rs0;
    logic [WORD-1:0] mem_data;
    logic [WORD-1:0] INST;

    logic [2:0]      ALUOP;
    logic [3:0]      DSOP;
    logic [3:0]      RSOP;
    logic [WORD-1:0] ds_data;
    logic            sr1_overwrite;
    logic [WORD-1:0] sr1_in;
    logic [WORD-1:0] rs_data;

    // sr1 only feeds the ALU; decode never needs it, so the master view omits it.
    modport master (
        input  STATUS, ALUOUT, sr0, rs0, mem_data, INST,
        output ALUOP, DSOP, RSOP, ds_data, sr1_overwrite, sr1_in, rs_data
    );

    modport slave (
        output STATUS, ALUOUT, sr0, sr1, rs0, mem_data, INST,
        input  ALUOP, DSOP, RSOP, ds_data, sr1_overwrite, sr1_in, rs_data
    );
endinterface

// File: rtl/stack_decode.sv
// Purely combinational instruction-word to micro-op decoder.
// Zero latency, no state, never stalls.
module stack_decode
    import stack_pkg::*;
(
    input  logic [WORD-1:0] i_inst,
    output uop_t            o_uop
);

    logic [4:0] w_opc;
    logic [4:0] w_alu_idx;

    assign w_opc     = i_inst[4:0];
    assign w_alu_idx = w_opc - OP_ALU_BASE;

    always_comb begin
        o_uop = '0;
        if (i_inst[WORD-1]) begin
            o_uop.dsop = DS_PUSH;
            o_uop.lit  = {1'b0, i_inst[WORD-2:0]};
            o_uop.sel  = SEL_LIT;
        end else begin
            case (w_opc) inside
                [OP_ALU_BASE:OP_ALU_LAST]: begin
                    // POP plus overwrite of the new second slot replaces both operands
                    o_uop.aluop  = alu_op_e'(w_alu_idx[2:0]);
                    o_uop.dsop   = DS_POP;
                    o_uop.sr1_ow = 1'b1;
                end
                OP_DUP:   o_uop.dsop = DS_DUP;
                OP_DROP:  o_uop.dsop = DS_POP;
                OP_SWAP:  o_uop.dsop = DS_SWAP;
                OP_OVER:  o_uop.dsop = DS_OVER;
                OP_TOR: begin
                    o_uop.rsop = RS_PUSH;
                    o_uop.dsop = DS_POP;
                end
                OP_FROMR: begin
                    o_uop.rsop = RS_POP;
                    o_uop.dsop = DS_PUSH;
                    o_uop.sel  = SEL_RS0;
                end
                OP_FETCH: begin
                    o_uop.dsop = DS_REPLACE;
                    o_uop.sel  = SEL_MEM;
                end
                OP_FLAGS: begin
                    o_uop.dsop = DS_PUSH;
                    o_uop.sel  = SEL_FLAGS;
                end
                default: o_uop = '0;
            endcase
        end
    end

endmodule

// File: rtl/stack_control.sv
// Decode/sequencing unit: registers decoded micro-ops, muxes datapath values onto stack buses.
// Latency 1 cycle, one instruction per cycle, no backpressure (never stalls).
module stack_control
    import stack_pkg::*;
(
    input  logic            clk,
    input  logic            async_reset,
    stack_control_if.master bus
);

    uop_t            w_uop;
    uop_t            r_uop;
    logic            w_ds_en;
    logic [WORD-1:0] w_ds_mux;

    stack_decode u_decode (
        .i_inst (bus.INST),
        .o_uop  (w_uop)
    );

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) r_uop <= '0;
        else              r_uop <= w_uop;
    end

    assign bus.ALUOP         = r_uop.aluop;
    assign bus.DSOP          = r_uop.dsop;
    assign bus.RSOP          = r_uop.rsop;
    assign bus.sr1_overwrite = r_uop.sr1_ow;

    // Data buses follow the live datapath inputs for the whole execute cycle.
    always_comb begin
        w_ds_mux = '0;
        case (r_uop.sel)
            SEL_LIT:   w_ds_mux = r_uop.lit;
            SEL_RS0:   w_ds_mux = bus.rs0;
            SEL_MEM:   w_ds_mux = bus.mem_data;
            SEL_FLAGS: w_ds_mux = {{(WORD-3){1'b0}}, bus.STATUS};
            default:   w_ds_mux = '0;
        endcase
    end

    assign w_ds_en     = (r_uop.dsop == DS_PUSH) || (r_uop.dsop == DS_REPLACE);
    assign bus.ds_data = w_ds_en ? w_ds_mux : '0;
    assign bus.sr1_in  = r_uop.sr1_ow ? bus.ALUOUT : '0;
    assign bus.rs_data = (r_uop.rsop == RS_PUSH) ? bus.sr0 : '0;

endmodule

// File: tb/tb_stack_control.sv
// Directed plus randomized bench for stack_control against a table-driven reference model.
module tb_stack_control;

    typedef struct packed {
        logic [2:0]  aluop;
        logic [3:0]  dsop;
        logic [3:0]  rsop;
        logic [15:0] ds;
        logic        ow;
        logic [15:0] sr1in;
        logic [15:0] rs;
    } exp_t;

    logic clk = 1'b0;
    logic async_reset;
    always #5 clk = ~clk;

    stack_control_if bus ();

    stack_control dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    logic [15:0] latched;
    int vec  = 0;
    int errs = 0;

    // Expected outputs from the instruction held in execute and the current datapath values.
    function automatic exp_t model(input logic [15:0] inst, input logic [2:0] st,
                                   input logic [15:0] alu, input logic [15:0] s0,
                                   input logic [15:0] r0, input logic [15:0] mem);
        exp_t e;
        int   opc;
        e   = '0;
        opc = int'(inst[4:0]);
        if (inst[15]) begin
            e.dsop = 4'd1;
            e.ds   = inst & 16'h7FFF;
        end else if (opc >= 1 && opc <= 8) begin
            e.aluop = 3'(opc - 1);
            e.dsop  = 4'd2;
            e.ow    = 1'b1;
            e.sr1in = alu;
        end else begin
            case (opc)
                9:  e.dsop = 4'd3;
                10: e.dsop = 4'd2;
                11: e.dsop = 4'd4;
                12: e.dsop = 4'd5;
                13: begin e.rsop = 4'd1; e.rs = s0; e.dsop = 4'd2; end
                14: begin e.rsop = 4'd2; e.dsop = 4'd1; e.ds = r0; end
                15: begin e.dsop = 4'd7; e.ds = mem; end
                16: begin e.dsop = 4'd1; e.ds = {13'd0, st}; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag);
        exp_t e;
        e = model(latched, bus.STATUS, bus.ALUOUT, bus.sr0, bus.rs0, bus.mem_data);
        vec++; assert (bus.ALUOP === e.aluop) else begin errs++;
            $error("FAIL %s ALUOP got %h want %h (inst %h)", tag, bus.ALUOP, e.aluop, latched); end
        vec++; assert (bus.DSOP === e.dsop) else begin errs++;
            $error("FAIL %s DSOP got %h want %h (inst %h)", tag, bus.DSOP, e.dsop, latched); end
        vec++; assert (bus.RSOP === e.rsop) else begin errs++;
            $error("FAIL %s RSOP got %h want %h (inst %h)", tag, bus.RSOP, e.rsop, latched); end
        vec++; assert (bus.ds_data === e.ds) else begin errs++;
            $error("FAIL %s ds_data got %h want %h (inst %h)", tag, bus.ds_data, e.ds, latched); end
        vec++; assert (bus.sr1_overwrite === e.ow) else begin errs++;
            $error("FAIL %s sr1_overwrite got %b want %b (inst %h)", tag, bus.sr1_overwrite, e.ow, latched); end
        vec++; assert (bus.sr1_in === e.sr1in) else begin errs++;
            $error("FAIL %s sr1_in got %h want %h (inst %h)", tag, bus.sr1_in, e.sr1in, latched); end
        vec++; assert (bus.rs_data === e.rs) else begin errs++;
            $error("FAIL %s rs_data got %h want %h (inst %h)", tag, bus.rs_data, e.rs, latched); end
    endtask

    task automatic drive_dp(input logic [2:0] st, input logic [15:0] alu, input logic [15:0] s0,
                            input logic [15:0] s1, input logic [15:0] r0, input logic [15:0] mem);
        bus.STATUS   = st;
        bus.ALUOUT   = alu;
        bus.sr0      = s0;
        bus.sr1      = s1;
        bus.rs0      = r0;
        bus.mem_data = mem;
    endtask

    task automatic drive_rand();
        drive_dp(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
    endtask

    // Present INST before an edge, let the edge sample it, then check in the execute cycle.
    task automatic step(input logic [15:0] inst, input string tag);
        @(negedge clk);
        bus.INST = inst;
        @(posedge clk);
        if (async_reset) latched = inst;
        #2;
        chk(tag);
    endtask

    initial begin
        async_reset = 1'b0;
        latched     = 16'h0000;
        bus.INST    = 16'h000D;
        drive_dp(3'b111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        #12;
        chk("reset_held");
        @(posedge clk);
        #3;
        chk("reset_held_edge");

        @(negedge clk);
        async_reset = 1'b1;
        step(16'h8004, "lit_4");
        step(16'h8005, "lit_5");
        step(16'h0000, "nop");
        step(16'hFFFF, "lit_max");

        drive_dp(3'b000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step(16'h0002, "alu_sub");
        #1;
        bus.ALUOUT = 16'h00FF;
        #1;
        chk("alu_live");

        drive_dp(3'b000, 16'h0000, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h0000);
        step(16'h000D, "tor");
        step(16'h000E, "fromr");

        drive_dp(3'b101, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A);
        step(16'h000F, "fetch");
        step(16'h0010, "flags");
        step(16'h001F, "op_1f");
        step(16'h7FE8, "alu_upper_ignored");

        drive_rand();
        step(16'h0003, "alu_and");
        #1;
        async_reset = 1'b0;
        latched     = 16'h0000;
        #1;
        chk("reset_mid");
        @(negedge clk);
        async_reset = 1'b1;
        step(16'h8123, "after_release");

        for (int i = 0; i < 400; i++) begin
            logic [15:0] inst;
            inst = 16'($urandom);
            if (i % 3 != 0) inst[15] = 1'b0;
            if (i % 5 == 1) inst[4:0] = 5'($urandom_range(0, 16));
            drive_rand();
            step(inst, "rand");
            if ($urandom_range(0, 1) == 1) begin
                drive_rand();
                #1;
                chk("rand_live");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
